// File: rtl/ntt_coeff_loader.sv
// ntt_coeff_loader
// Input stage in front of the NTT core. It takes a serial stream of
// coefficients over a valid/ready handshake and reduces each one modulo Q.
// Four consecutive coefficients are packed into one group, and the group is
// written to four data banks in a single cycle. The bank/address mapping
// never places two coefficients of the same group in the same bank. When
// the whole polynomial has been written, load_done pulses to release the
// NTT core.
//
// Ports
//   clk                      system clock, rising edge
//   rst                      asynchronous, active-low reset
//   start                    one-cycle request to load a polynomial (honoured in IDLE only)
//   s_valid / s_data         coefficient stream, natural order, index 0 first
//   s_ready                  high while the loader accepts coefficients
//   busy                     high from the accepted start until load_done
//   bank_wen[3:0]            per-bank write enable; all four bits pulse together
//   bank_addr_0..3           write address for each bank (a[6:2] of the group)
//   bank_d_0..3              write data for each bank
//   load_done                one-cycle pulse once the polynomial is resident
//   coef_count[7:0]          coefficients accepted in the current load, saturates at N
module ntt_coeff_loader #(
  parameter int DATA_WIDTH = 12,
  parameter int Q          = 3329,
  parameter int N          = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  busy,
  output logic [3:0]            bank_wen,
  output logic [4:0]            bank_addr_0,
  output logic [4:0]            bank_addr_1,
  output logic [4:0]            bank_addr_2,
  output logic [4:0]            bank_addr_3,
  output logic [DATA_WIDTH-1:0] bank_d_0,
  output logic [DATA_WIDTH-1:0] bank_d_1,
  output logic [DATA_WIDTH-1:0] bank_d_2,
  output logic [DATA_WIDTH-1:0] bank_d_3,
  output logic                  load_done,
  output logic [7:0]            coef_count
);

  typedef enum logic [1:0] {IDLE, LOAD, LAST_WR, DONE} state_t;

  state_t                         state_q;
  logic                           s_ready_q;
  logic                           busy_q;
  logic                           load_done_q;
  logic [7:0]                     count_q;
  logic [3:0][DATA_WIDTH-1:0]     slot_q;   // coefficients of the group being assembled
  logic [3:0]                     wen_q;
  logic [4:0]                     addr_q;
  logic [3:0][DATA_WIDTH-1:0]     wdata_q;  // bank-ordered write data, separate from slot_q

  logic                           accept;
  logic [6:0]                     idx;
  logic [DATA_WIDTH-1:0]          red;
  logic [1:0]                     bank_off;
  logic [3:0][DATA_WIDTH-1:0]     group;
  logic [3:0][DATA_WIDTH-1:0]     perm_d;

  assign accept = s_valid & s_ready_q;
  // The index of the beat being accepted is the number of beats already taken.
  assign idx    = count_q[6:0];

  // A single conditional subtract is enough because the input is below 2*Q.
  assign red = (s_data >= DATA_WIDTH'(Q)) ? s_data - DATA_WIDTH'(Q) : s_data;

  // Every index in a group shares a[6:2]. The bank is therefore slot + offset
  // (mod 4), and the offset is the same for the whole group.
  assign bank_off = idx[3:2] + idx[5:4] + {1'b0, idx[6]};

  // Slot 3 is taken from the beat accepted now; slots 0..2 were stored earlier.
  assign group = {red, slot_q[2], slot_q[1], slot_q[0]};

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    perm_d = '0;
    for (int b = 0; b < 4; b++) begin
      perm_d[b] = group[2'(2'(b) - bank_off)];
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      count_q     <= '0;
      // NOTE: the slot and write registers are small flop arrays, not RAM, so they are reset; after a reset nothing stale can be written.
      slot_q      <= '0;
      wen_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      wen_q <= '0;

      if (accept) begin
        slot_q[idx[1:0]] <= red;
        if (idx[1:0] == 2'd3) begin
          wen_q   <= 4'hF;
          addr_q  <= idx[6:2];
          wdata_q <= perm_d;
        end
        if (count_q != 8'(N)) begin
          count_q <= count_q + 8'd1;
        end
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= LOAD;
            busy_q    <= 1'b1;
            s_ready_q <= 1'b1;
            count_q   <= '0;
          end
        end
        LOAD: begin
          if (accept && idx == 7'(N - 1)) begin
            state_q   <= LAST_WR;
            s_ready_q <= 1'b0;
          end
        end
        LAST_WR: begin
          state_q     <= DONE;
          load_done_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        DONE: begin
          state_q     <= IDLE;
          load_done_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready     = s_ready_q;
  assign busy        = busy_q;
  assign load_done   = load_done_q;
  assign coef_count  = count_q;
  assign bank_wen    = wen_q;
  assign bank_addr_0 = addr_q;
  assign bank_addr_1 = addr_q;
  assign bank_addr_2 = addr_q;
  assign bank_addr_3 = addr_q;
  assign bank_d_0    = wdata_q[0];
  assign bank_d_1    = wdata_q[1];
  assign bank_d_2    = wdata_q[2];
  assign bank_d_3    = wdata_q[3];

endmodule
